// File: rtl/router_egress_arbiter.sv
// Packet-granular round-robin drain of the router's three output FIFOs onto one egress byte bus.
// Latency: read strobe is combinational; the byte appears on egress one cycle after its read.
// Backpressure: egress_ready gates new reads only; a read already issued is always presented next cycle.
//
// Ports:
//   clk, resetn                 clock; synchronous active-high reset (name kept for codebase consistency)
//   vld_out_n / data_out_n      FIFO n non-empty flag / read data (valid one cycle after read_enb_n)
//   read_enb_n                  combinational FIFO read strobes, one-hot or zero
//   egress_valid/_data/_sop/_eop  registered egress byte stream
//   grant                       port owning the bus (0..2), 3 = none
//   busy                        a packet is in progress
//   parity_err                  (only with EGRESS_PARITY_CHK_EN) 1-cycle pulse on eop when parity mismatches
//
// Optional feature macro: EGRESS_PARITY_CHK_EN
module router_egress_arbiter #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vld_out_0,
  input  logic              vld_out_1,
  input  logic              vld_out_2,
  input  logic [DATA_W-1:0] data_out_0,
  input  logic [DATA_W-1:0] data_out_1,
  input  logic [DATA_W-1:0] data_out_2,
  input  logic              egress_ready,
  output logic              read_enb_0,
  output logic              read_enb_1,
  output logic              read_enb_2,
  output logic              egress_valid,
  output logic [DATA_W-1:0] egress_data,
  output logic              egress_sop,
  output logic              egress_eop,
  output logic [1:0]        grant,
  output logic              busy
`ifdef EGRESS_PARITY_CHK_EN
  ,
  output logic              parity_err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        grant_q;
  logic [1:0]        rd_port_q;
  logic [LEN_W:0]    remaining;
  logic              ev_q, sop_q, eop_q;

  logic [2:0]        vld;
  logic [1:0]        cand1, cand2;
  logic              pick_vld;
  logic [1:0]        pick_port;
  logic              g_vld;
  logic [LEN_W-1:0]  hdr_len;
  logic [DATA_W-1:0] dsel_q;
  logic              rd_fire, rd_hdr, rd_last;
  logic [1:0]        rd_port;
  logic [2:0]        rd_vec;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic vld_of(input logic [2:0] v, input logic [1:0] p);
    case (p)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  assign vld   = {vld_out_2, vld_out_1, vld_out_0};
  assign cand1 = inc3(rr_ptr);
  assign cand2 = inc3(cand1);

  // Lowest-distance candidate from rr_ptr wins; evaluated farthest first so the nearest overrides.
  always_comb begin
    pick_vld  = 1'b0;
    pick_port = 2'd0;
    if (vld_of(vld, cand2)) begin
      pick_vld  = 1'b1;
      pick_port = cand2;
    end
    if (vld_of(vld, cand1)) begin
      pick_vld  = 1'b1;
      pick_port = cand1;
    end
    if (vld_of(vld, rr_ptr)) begin
      pick_vld  = 1'b1;
      pick_port = rr_ptr;
    end
  end

  assign g_vld = vld_of(vld, grant_q);

  // Length field of the header currently on the granted FIFO's data bus (used in HDR).
  always_comb begin
    case (grant_q)
      2'd0:    hdr_len = data_out_0[DATA_W-1 -: LEN_W];
      2'd1:    hdr_len = data_out_1[DATA_W-1 -: LEN_W];
      2'd2:    hdr_len = data_out_2[DATA_W-1 -: LEN_W];
      default: hdr_len = '0;
    endcase
  end

  always_comb begin
    case (rd_port_q)
      2'd0:    dsel_q = data_out_0;
      2'd1:    dsel_q = data_out_1;
      2'd2:    dsel_q = data_out_2;
      default: dsel_q = '0;
    endcase
  end

  // Read decision. Strobes are held low while reset is asserted so no FIFO byte is lost to it.
  always_comb begin
    rd_fire = 1'b0;
    rd_hdr  = 1'b0;
    rd_last = 1'b0;
    rd_port = grant_q;
    if (!resetn) begin
      case (state)
        IDLE: begin
          if (pick_vld && egress_ready) begin
            rd_fire = 1'b1;
            rd_hdr  = 1'b1;
            rd_port = pick_port;
          end
        end
        BODY: begin
          if (g_vld && egress_ready && (remaining != '0)) begin
            rd_fire = 1'b1;
            rd_last = (remaining == (LEN_W+1)'(1));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_vec = 3'b000;
    if (rd_fire) begin
      case (rd_port)
        2'd0:    rd_vec = 3'b001;
        2'd1:    rd_vec = 3'b010;
        2'd2:    rd_vec = 3'b100;
        default: rd_vec = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= IDLE;
      rr_ptr    <= 2'd0;
      grant_q   <= 2'd3;
      remaining <= '0;
      rd_port_q <= 2'd0;
      ev_q      <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      ev_q  <= rd_fire;
      sop_q <= rd_hdr;
      eop_q <= rd_last;
      if (rd_fire) rd_port_q <= rd_port;
      case (state)
        IDLE: begin
          if (rd_fire) begin
            grant_q <= pick_port;
            state   <= HDR;
          end else begin
            grant_q <= 2'd3;
          end
        end
        HDR: begin
          // Payload bytes plus the trailing parity byte.
          remaining <= {1'b0, hdr_len} + (LEN_W+1)'(1);
          state     <= BODY;
        end
        BODY: begin
          if (rd_fire) begin
            remaining <= remaining - (LEN_W+1)'(1);
            if (rd_last) begin
              rr_ptr <= inc3(grant_q);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign read_enb_0   = rd_vec[0];
  assign read_enb_1   = rd_vec[1];
  assign read_enb_2   = rd_vec[2];
  assign egress_valid = ev_q;
  assign egress_sop   = sop_q;
  assign egress_eop   = eop_q;
  assign egress_data  = ev_q ? dsel_q : '0;
  assign grant        = grant_q;
  assign busy         = (state != IDLE);

`ifdef EGRESS_PARITY_CHK_EN
  logic [DATA_W-1:0] run_xor;

  // Restarts on the header; by the eop cycle it holds header ^ payload.
  always_ff @(posedge clk) begin
    if (resetn) begin
      run_xor <= '0;
    end else if (ev_q) begin
      run_xor <= sop_q ? egress_data : (run_xor ^ egress_data);
    end
  end

  assign parity_err = ev_q & eop_q & (run_xor != egress_data);
`endif

endmodule

// File: tb/tb_router_egress_arbiter.sv
module tb_router_egress_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic [2:0] vld;
  logic [7:0] dout [3];
  logic       egress_ready;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       egress_valid, egress_sop, egress_eop, busy;
  logic [7:0] egress_data;
  logic [1:0] grant;
`ifdef EGRESS_PARITY_CHK_EN
  logic       parity_err;
`endif

  router_egress_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .vld_out_0    (vld[0]),
    .vld_out_1    (vld[1]),
    .vld_out_2    (vld[2]),
    .data_out_0   (dout[0]),
    .data_out_1   (dout[1]),
    .data_out_2   (dout[2]),
    .egress_ready (egress_ready),
    .read_enb_0   (read_enb_0),
    .read_enb_1   (read_enb_1),
    .read_enb_2   (read_enb_2),
    .egress_valid (egress_valid),
    .egress_data  (egress_data),
    .egress_sop   (egress_sop),
    .egress_eop   (egress_eop),
    .grant        (grant),
    .busy         (busy)
`ifdef EGRESS_PARITY_CHK_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  typedef struct {
    logic [7:0] d;
    bit         sop;
    bit         eop;
    bit         perr;
    logic [1:0] port;
  } exp_t;

  logic [7:0] fq [3][$];     // FIFO contents seen by the DUT
  logic [7:0] mq [3][$];     // reference model's copy of pending packets
  bit         mperr [3][$];  // per-packet "parity corrupted" flag
  exp_t       exp_q [$];
  bit         hold [3];
  int         rr_m;
  int         checks = 0;
  int         passes = 0;
  bit         mon_en = 1'b0;
  logic [2:0] rd_s;
  logic [2:0] rdl [32];
  bit [31:0]  vl, el;
  int         lc;

  task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
  endtask

  task automatic update_vld();
    for (int n = 0; n < 3; n++) vld[n] = (fq[n].size() != 0) && !hold[n];
  endtask

  // One clock: sample strobes mid-cycle, then apply FIFO pops just after the edge.
  task automatic tick();
    update_vld();
    @(negedge clk);
    rd_s = {read_enb_2, read_enb_1, read_enb_0};
    if (lc < 32) begin
      rdl[lc] = rd_s;
      vl[lc]  = egress_valid;
      el[lc]  = egress_eop;
      lc++;
    end
    if (rd_s != 3'b000) check("rd_onehot", $countones(rd_s), 1);
    if (!egress_ready) check("rd_while_not_ready", {29'd0, rd_s}, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (rd_s[n]) begin
        check("rd_fifo_nonempty", fq[n].size() != 0, 1);
        if (fq[n].size() != 0) dout[n] = fq[n].pop_front();
      end
    end
    update_vld();
  endtask

  function automatic bit [31:0] col(int p);
    bit [31:0] r = '0;
    for (int i = 0; i < 32; i++) r[i] = rdl[i][p];
    return r;
  endfunction

  task automatic start_log();
    lc = 0;
    vl = '0;
    el = '0;
    for (int i = 0; i < 32; i++) rdl[i] = 3'b000;
  endtask

  // Packet: header {len,addr}, len payload bytes, parity = XOR of header and payload.
  task automatic load_pkt(int p, int len, int addr, bit corrupt, bit rnd);
    logic [7:0] h, b, par;
    h   = {len[5:0], addr[1:0]};
    par = h;
    fq[p].push_back(h);
    mq[p].push_back(h);
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : ((i == 0) ? 8'hAA : (i == 1) ? 8'h55 : 8'(i));
      par ^= b;
      fq[p].push_back(b);
      mq[p].push_back(b);
    end
    if (corrupt) par ^= 8'h01;
    fq[p].push_back(par);
    mq[p].push_back(par);
    mperr[p].push_back(corrupt);
  endtask

  // Packet-level round robin over everything currently pending in the model.
  task automatic model_drain();
    int p, n;
    logic [7:0] h;
    while (mq[0].size() + mq[1].size() + mq[2].size() != 0) begin
      p = -1;
      for (int k = 0; k < 3; k++)
        if (p < 0 && mq[(rr_m + k) % 3].size() != 0) p = (rr_m + k) % 3;
      h = mq[p].pop_front();
      n = int'(h[7:2]);
      exp_q.push_back('{d: h, sop: 1'b1, eop: 1'b0, perr: 1'b0, port: 2'(p)});
      for (int i = 0; i < n; i++)
        exp_q.push_back('{d: mq[p].pop_front(), sop: 1'b0, eop: 1'b0, perr: 1'b0, port: 2'(p)});
      exp_q.push_back('{d: mq[p].pop_front(), sop: 1'b0, eop: 1'b1, perr: mperr[p].pop_front(), port: 2'(p)});
      rr_m = (p + 1) % 3;
    end
  endtask

  task automatic run_until_done(int maxc, bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      if (rnd) begin
        egress_ready = ($urandom_range(3) != 0);
        for (int k = 0; k < 3; k++) hold[k] = busy && ($urandom_range(4) == 0);
      end
      tick();
      n++;
    end
    egress_ready = 1'b1;
    for (int k = 0; k < 3; k++) hold[k] = 1'b0;
    check("drain_within_budget", n < maxc, 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (egress_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, egress_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("egress_data", egress_data, e.d);
          check("egress_sop", egress_sop, e.sop);
          check("egress_eop", egress_eop, e.eop);
          check("grant_during_pkt", grant, e.port);
`ifdef EGRESS_PARITY_CHK_EN
          check("parity_err", parity_err, e.perr);
`endif
        end
      end else begin
        check("idle_sop_eop", {egress_sop, egress_eop}, 0);
      end
    end
  end

  task automatic check_quiet(string nm);
    check({nm, "_rd"}, {read_enb_2, read_enb_1, read_enb_0}, 0);
    check({nm, "_flags"}, {egress_valid, egress_sop, egress_eop, busy}, 0);
    check({nm, "_data"}, egress_data, 0);
    check({nm, "_grant"}, grant, 3);
  endtask

  initial begin
    bit [31:0] ev;
    resetn       = 1'b1;
    egress_ready = 1'b1;
    vld          = 3'b000;
    for (int n = 0; n < 3; n++) begin
      dout[n] = 8'h00;
      hold[n] = 1'b0;
    end
    rr_m = 0;
    lc   = 0;

    tick();
    tick();
    check_quiet("reset");
    resetn = 1'b0;
    mon_en = 1'b1;

    // Three simultaneous packets: strict 0,1,2 order, 5 cycles per 4-byte packet.
    for (int p = 0; p < 3; p++) load_pkt(p, 2, p, 1'b0, 1'b1);
    model_drain();
    start_log();
    repeat (17) tick();
    ev = '0;
    for (int k = 0; k < 3; k++)
      ev |= (32'd1 << (5*k+1)) | (32'd1 << (5*k+3)) | (32'd1 << (5*k+4)) | (32'd1 << (5*k+5));
    check("b2b_valid_pattern", vl & 32'h1FFFF, ev);
    check("b2b_hdr_reads", {rdl[0], rdl[5], rdl[10]}, {3'b001, 3'b010, 3'b100});
    run_until_done(50, 1'b0);

    // Single packet on port 1: 0x09, 0xAA, 0x55, parity.
    load_pkt(1, 2, 1, 1'b0, 1'b0);
    model_drain();
    start_log();
    repeat (7) tick();
    check("p1_read_cycles", col(1) & 32'h7F, 32'b0011101);
    check("p1_other_reads", (col(0) | col(2)) & 32'h7F, 0);
    check("p1_valid_cycles", vl & 32'h7F, 32'b0111010);
    check("p1_eop_cycle", el & 32'h7F, 32'b0100000);
    run_until_done(50, 1'b0);

    // len=0 on port 2: header 0x02 then parity only.
    load_pkt(2, 0, 2, 1'b0, 1'b1);
    model_drain();
    start_log();
    repeat (5) tick();
    check("len0_reads", col(2) & 32'h1F, 32'b00101);
    check("len0_valid", vl & 32'h1F, 32'b01010);
    check("len0_eop", el & 32'h1F, 32'b01000);
    run_until_done(50, 1'b0);

    // egress_ready low for three cycles in BODY.
    load_pkt(0, 6, 0, 1'b0, 1'b1);
    model_drain();
    repeat (4) tick();
    egress_ready = 1'b0;
    repeat (3) tick();
    egress_ready = 1'b1;
    run_until_done(50, 1'b0);

    // Granted FIFO stalls while another port has data: no port switch.
    load_pkt(0, 5, 3, 1'b0, 1'b1);
    model_drain();
    repeat (4) tick();
    load_pkt(1, 1, 0, 1'b0, 1'b1);
    model_drain();
    hold[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_no_read", {29'd0, rd_s}, 0);
      check("stall_grant", grant, 0);
    end
    hold[0] = 1'b0;
    run_until_done(60, 1'b0);

`ifdef EGRESS_PARITY_CHK_EN
    load_pkt(2, 3, 1, 1'b1, 1'b1);
    model_drain();
    run_until_done(50, 1'b0);
`endif

    // Reset mid-packet, after leaving the pointer at port 2.
    load_pkt(1, 1, 1, 1'b0, 1'b1);
    model_drain();
    run_until_done(50, 1'b0);
    load_pkt(2, 6, 2, 1'b0, 1'b1);
    model_drain();
    repeat (5) tick();
    check("pre_reset_busy", busy, 1);
    mon_en = 1'b0;
    resetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      fq[n].delete();
      mq[n].delete();
      mperr[n].delete();
      dout[n] = 8'h00;
    end
    tick();
    resetn = 1'b0;
    check_quiet("mid_pkt_reset");
    exp_q.delete();
    rr_m   = 0;
    mon_en = 1'b1;
    load_pkt(2, 2, 0, 1'b0, 1'b1);
    load_pkt(1, 1, 0, 1'b0, 1'b1);
    load_pkt(0, 3, 0, 1'b0, 1'b1);
    model_drain();
    run_until_done(60, 1'b0);

    // Randomised rounds with ready and stall noise.
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < 3; p++) begin
        int np = $urandom_range(2);
        for (int j = 0; j < np; j++) begin
`ifdef EGRESS_PARITY_CHK_EN
          load_pkt(p, $urandom_range(9), $urandom_range(3), $urandom_range(3) == 0, 1'b1);
`else
          load_pkt(p, $urandom_range(9), $urandom_range(3), 1'b0, 1'b1);
`endif
        end
      end
      model_drain();
      run_until_done(2000, 1'b1);
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
